// File: rtl/proc_ctrl.sv
// proc_ctrl: control sequencer for a simple bus-based processor.
//
// It latches a 9-bit instruction from din[8:0] and steps a 4-state FSM
// (T0..T3) to execute mv, mvi, add and sub. It is the only source of the
// ALU stage's ain/gin/sub controls, the register-file load/drive enables
// and the bus source selects.
//
// Ports:
//   clock    in            system clock, rising edge
//   reset    in            synchronous, active-high reset
//   run      in            start request, sampled only in T0
//   din      in  [DATA_W]  instruction / immediate word; din[8:0] loads IR
//   ir       out [9]       current instruction register
//   irin     out           IR load enable (asserted in T0 while run=1)
//   rin      out [NREG]    one-hot register load enables
//   rout     out [NREG]    one-hot register bus-drive enables
//   gout     out           G register drives the bus
//   dinout   out           din drives the bus
//   ain      out           ALU A-register load
//   gin      out           ALU G-register load
//   sub      out           ALU subtract select (1 = A - bus)
//   done     out           one-cycle pulse on the final step of an instruction
//   o_state  out [2]       current FSM step (0=T0 .. 3=T3), for observability
//
// Handshake: in T0 the block accepts an instruction on any edge where
// run=1 (irin mirrors run in that cycle). run is ignored in T1..T3, so
// holding it high chains instructions back to back. done marks the cycle
// in which the last register write of the instruction happens.
//
// All outputs are combinational decodes of the registered state and IR.

module proc_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [8:0]        ir,
    output logic              irin,
    output logic [NREG-1:0]   rin,
    output logic [NREG-1:0]   rout,
    output logic              gout,
    output logic              dinout,
    output logic              ain,
    output logic              gin,
    output logic              sub,
    output logic              done,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t      r_state;
    logic [8:0]  r_ir;

    logic [2:0]      w_op;
    logic [2:0]      w_x;
    logic [2:0]      w_y;
    logic            w_is_arith;
    logic [NREG-1:0] w_x_hot;
    logic [NREG-1:0] w_y_hot;

    // Only the low nine bits of din form an instruction; the rest feed the
    // datapath elsewhere and are deliberately ignored here.
    logic w_unused_din;
    assign w_unused_din = ^din[DATA_W-1:9];

    assign w_op       = r_ir[8:6];
    assign w_x        = r_ir[5:3];
    assign w_y        = r_ir[2:0];
    assign w_is_arith = (w_op == OP_ADD) || (w_op == OP_SUB);
    assign w_x_hot    = NREG'(1) << w_x;
    assign w_y_hot    = NREG'(1) << w_y;

    always_ff @(posedge clock) begin
        if (reset) begin
            // Abandons any instruction in flight; T0 decodes no enables.
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                T0: begin
                    if (run) begin
                        r_ir    <= din[8:0];
                        r_state <= T1;
                    end
                end
                T1:      r_state <= w_is_arith ? T2 : T0;
                T2:      r_state <= T3;
                T3:      r_state <= T0;
                default: r_state <= T0;
            endcase
        end
    end

    always_comb begin
        irin   = 1'b0;
        rin    = '0;
        rout   = '0;
        gout   = 1'b0;
        dinout = 1'b0;
        ain    = 1'b0;
        gin    = 1'b0;
        sub    = 1'b0;
        done   = 1'b0;
        case (r_state)
            T0: irin = run;
            T1: begin
                case (w_op)
                    OP_MV: begin
                        rout = w_y_hot;
                        rin  = w_x_hot;
                        done = 1'b1;
                    end
                    OP_MVI: begin
                        dinout = 1'b1;
                        rin    = w_x_hot;
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout = w_x_hot;
                        ain  = 1'b1;
                    end
                    default: done = 1'b1;  // NOP: finish with no enables
                endcase
            end
            T2: begin
                // Reached only by add/sub; with X = Y the bus simply carries
                // the same register that A captured in T1.
                rout = w_y_hot;
                gin  = 1'b1;
                sub  = (w_op == OP_SUB);
            end
            T3: begin
                gout = 1'b1;
                rin  = w_x_hot;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign ir      = r_ir;
    assign o_state = r_state;

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed testbench for proc_ctrl. Inputs change just after the falling
// edge and outputs are checked 1 ns later, well away from the rising edge.

module tb_proc_ctrl;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic [8:0]  ir;
    logic        irin;
    logic [7:0]  rin;
    logic [7:0]  rout;
    logic        gout;
    logic        dinout;
    logic        ain;
    logic        gin;
    logic        sub;
    logic        done;
    logic [1:0]  o_state;

    int n_cmp = 0;
    int n_err = 0;
    logic inv_en = 1'b0;

    proc_ctrl #(.DATA_W(16), .NREG(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .din     (din),
        .ir      (ir),
        .irin    (irin),
        .rin     (rin),
        .rout    (rout),
        .gout    (gout),
        .dinout  (dinout),
        .ain     (ain),
        .gin     (gin),
        .sub     (sub),
        .done    (done),
        .o_state (o_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- check helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packed as {irin, rin, rout, gout, dinout, ain, gin, sub, done}
    task automatic chk_outs(input string tag, input logic e_irin,
                            input logic [7:0] e_rin, input logic [7:0] e_rout,
                            input logic e_gout, input logic e_dinout,
                            input logic e_ain, input logic e_gin,
                            input logic e_sub, input logic e_done);
        chk(tag,
            32'({irin, rin, rout, gout, dinout, ain, gin, sub, done}),
            32'({e_irin, e_rin, e_rout, e_gout, e_dinout, e_ain, e_gin, e_sub, e_done}));
    endtask

    // Drive one cycle of inputs after the falling edge, then let them settle.
    task automatic step(input logic s_reset, input logic s_run, input logic [15:0] s_din);
        @(negedge clock);
        reset = s_reset;
        run   = s_run;
        din   = s_din;
        #1;
    endtask

    // ---------------- invariants, every cycle ----------------
    always @(negedge clock) begin
        if (inv_en) begin
            chk("inv_bus_excl", 32'(($countones(rout) + 32'(gout) + 32'(dinout)) <= 1), 32'd1);
            chk("inv_rin_onehot0", 32'($onehot0(rin)), 32'd1);
            chk("inv_rout_onehot0", 32'($onehot0(rout)), 32'd1);
            chk("inv_done_state", 32'(done && (o_state == 2'd0 || o_state == 2'd2)), 32'd0);
            chk("inv_sub_state", 32'(sub && (o_state != 2'd2)), 32'd0);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        run   = 1'b0;
        din   = 16'h0000;

        // Reset for two cycles with run low, then five idle cycles.
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        inv_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            chk("idle_ir", 32'(ir), 32'h000);
            chk("idle_state", 32'(o_state), 32'd0);
            chk_outs("idle_outs", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // mvi R1 (0x048): 2 cycles. Upper din bits are junk and must not matter.
        step(1'b0, 1'b1, 16'hFE48);
        chk_outs("mvi_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000);
        chk("mvi_ir", 32'(ir), 32'h048);
        chk("mvi_t1_state", 32'(o_state), 32'd1);
        chk_outs("mvi_t1", 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000);
        chk("mvi_back_t0", 32'(o_state), 32'd0);
        chk_outs("mvi_after", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // mv R1,R2 (0x00A)
        step(1'b0, 1'b1, 16'h000A);
        chk_outs("mv_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000);
        chk_outs("mv_t1", 1'b0, 8'h02, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000);
        chk("mv_back_t0", 32'(o_state), 32'd0);

        // add R4,R1 (0x0A1): 4 cycles
        step(1'b0, 1'b1, 16'h00A1);
        chk_outs("add_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0048);  // run ignored outside T0
        chk_outs("add_t1", 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0048);
        chk_outs("add_t2", 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("add_ir_stable", 32'(ir), 32'h0A1);
        step(1'b0, 1'b0, 16'h0000);
        chk_outs("add_t3", 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000);
        chk("add_back_t0", 32'(o_state), 32'd0);
        chk_outs("add_after", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // sub R3,R3 (0x0DB) with reset asserted during T2
        step(1'b0, 1'b1, 16'h00DB);
        chk_outs("sub_t0", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000);
        chk_outs("sub_t1", 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0048);  // reset wins over run
        chk_outs("sub_t2", 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_ir", 32'(ir), 32'h000);
        chk_outs("rst_outs", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000);
        chk_outs("rst_outs2", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back to back, run held high: mvi R0 (0x040) then NOP (0x100)
        step(1'b0, 1'b1, 16'h0040);
        chk_outs("b2b_c1", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0100);
        chk_outs("b2b_c2", 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_c2_ir", 32'(ir), 32'h040);
        step(1'b0, 1'b1, 16'h0100);
        chk("b2b_c3_state", 32'(o_state), 32'd0);
        chk_outs("b2b_c3", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000);
        chk("b2b_c4_ir", 32'(ir), 32'h100);
        chk_outs("b2b_c4", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000);
        chk("b2b_c5_state", 32'(o_state), 32'd0);
        chk_outs("b2b_c5", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_ir_held", 32'(ir), 32'h100);

        inv_en = 1'b0;
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
